// File: rtl/uart_tx_mmio.sv
// Memory-mapped console transmitter: byte FIFO feeding an 8N1 serialiser on tx.
// Frames run back to back while the FIFO holds data. A dropped write sets a sticky overflow flag.
module uart_tx_mmio #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          overflow,
    output logic          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [7:0]    mem [FIFO_DEPTH];

    logic push, pop, div_last;

    // Acceptance looks only at the pre-edge occupancy; a same-edge pop does not free a slot.
    assign push     = wr_en && !full;
    assign div_last = (div_q == DW'(CLK_DIV - 1));

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign busy     = (state_q != StIdle);
    assign overflow = overflow_q;
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rptr_q];
                    tx_d    = 1'b0;
                    div_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (div_last) begin
                    div_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StData: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StStop: begin
                if (div_last) begin
                    div_d = '0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rptr_q];
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: three divider settings share one stimulus stream; every cycle each
// instance is compared to a frame-time reference model (queue plus cycles-since-start-bit).
module tb_uart_tx_mmio;

    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full_w [3];
    logic       empty_w [3];
    logic       busy_w [3];
    logic       ovf_w [3];
    logic       tx_w [3];
    logic [2:0] cnt_w [3];

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLK_DIV(4), .FIFO_DEPTH(FD), .CW(3)) u_div4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_w[0]),
        .empty(empty_w[0]), .count(cnt_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0]),
        .tx(tx_w[0])
    );
    uart_tx_mmio #(.CLK_DIV(2), .FIFO_DEPTH(FD), .CW(3)) u_div2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_w[1]),
        .empty(empty_w[1]), .count(cnt_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1]),
        .tx(tx_w[1])
    );
    uart_tx_mmio #(.CLK_DIV(7), .FIFO_DEPTH(FD), .CW(3)) u_div7 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_w[2]),
        .empty(empty_w[2]), .count(cnt_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2]),
        .tx(tx_w[2])
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a byte queue plus the number of cycles since the current start bit.
    int         mdiv [3] = '{4, 2, 7};
    logic [7:0] mq [3][FD];
    int         mh [3];
    int         ms [3];
    int         mt [3];
    bit         mact [3];
    bit         movf [3];
    logic [7:0] mcur [3];

    function automatic void model_pop(int k);
        mcur[k] = mq[k][mh[k]];
        mh[k]   = (mh[k] + 1) % FD;
        ms[k]   = ms[k] - 1;
        mt[k]   = 0;
        mact[k] = 1'b1;
    endfunction

    function automatic void model_step(int k, logic r, logic w, logic [7:0] d);
        int pre;
        if (r) begin
            mh[k] = 0; ms[k] = 0; mt[k] = 0; mact[k] = 1'b0; movf[k] = 1'b0;
            return;
        end
        pre = ms[k];
        if (mact[k]) begin
            mt[k] = mt[k] + 1;
            if (mt[k] == 10 * mdiv[k]) begin
                if (pre > 0) model_pop(k);
                else mact[k] = 1'b0;
            end
        end else if (pre > 0) begin
            model_pop(k);
        end
        if (w) begin
            if (pre == FD) begin
                movf[k] = 1'b1;
            end else begin
                mq[k][(mh[k] + ms[k]) % FD] = d;
                ms[k] = ms[k] + 1;
            end
        end
    endfunction

    function automatic logic exp_tx(int k);
        int t  = mt[k];
        int dv = mdiv[k];
        if (!mact[k]) return 1'b1;
        if (t < dv) return 1'b0;
        if (t < 9 * dv) return mcur[k][t / dv - 1];
        return 1'b1;
    endfunction

    function automatic bit all_idle();
        for (int k = 0; k < 3; k++) if (mact[k] || ms[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input logic r, input logic w, input logic [7:0] d);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, w, d);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            string p = $sformatf("div%0d", mdiv[k]);
            check({p, " tx"}, 32'(tx_w[k]), 32'(exp_tx(k)));
            check({p, " busy"}, 32'(busy_w[k]), 32'(mact[k]));
            check({p, " count"}, 32'(cnt_w[k]), 32'(ms[k]));
            check({p, " empty"}, 32'(empty_w[k]), 32'(ms[k] == 0));
            check({p, " full"}, 32'(full_w[k]), 32'(ms[k] == FD));
            check({p, " overflow"}, 32'(ovf_w[k]), 32'(movf[k]));
        end
    endtask

    task automatic run_idle();
        int n = 0;
        while (!all_idle() && n < 2000) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'(n), 32'd0);
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_frame_time(input int target);
        int n = 0;
        while (!(mact[0] && mt[0] == target) && n < 200) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= 200) check("frame_wait_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);

        // Single byte, then back-to-back pair.
        cycle(1'b0, 1'b1, 8'h55);
        run_idle();
        cycle(1'b0, 1'b1, 8'hA5);
        cycle(1'b0, 1'b1, 8'h3C);
        run_idle();

        // Fill past capacity: the sixth write is dropped and overflow sticks.
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 8'(i));
        run_idle();
        check("overflow_sticky", 32'(ovf_w[0]), 32'd1);

        // Write while full on the very edge the stop bit ends and the head is popped.
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i));
        wait_frame_time(10 * 4 - 1);
        cycle(1'b0, 1'b1, 8'hEE);
        check("full_pop_count", 32'(cnt_w[0]), 32'd3);
        check("full_pop_overflow", 32'(ovf_w[0]), 32'd1);
        run_idle();

        // Reset during data bit 3 with two bytes queued.
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i));
        wait_frame_time(4 * 4 + 1);
        cycle(1'b1, 1'b0, 8'h00);
        check("midframe_rst_tx", 32'(tx_w[0]), 32'd1);
        check("midframe_rst_busy", 32'(busy_w[0]), 32'd0);
        check("midframe_rst_count", 32'(cnt_w[0]), 32'd0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 8'h00);

        // Extreme data patterns across all dividers.
        cycle(1'b0, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'h00);
        run_idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(299) == 0), 1'($urandom_range(5) == 0), 8'($urandom));
        end
        run_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped serial console transmitter on the `machine` peripheral bus, directly downstream of the CPU's store path.
- Consumes byte stores issued by `cpu0` to the console address (decode is done in `machine`), buffers them in a small FIFO and serialises them 8N1 on `tx`.
- Provides the character-output channel that simulation benches and the eventual FPGA top use to watch program output.

Parameters:
- CLK_DIV, 4: clock cycles per serial bit. Integer ≥ 2.
- FIFO_DEPTH, 4: FIFO entries. Power of two, ≥ 2.
- CW, 3: width of `count`. Must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  single-cycle store strobe from bus decode.
- wr_data  in  8  byte to transmit (store data bits [7:0]).
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  CW  FIFO occupancy; excludes the byte in the shifter.
- busy  out  1  shifter active (state ≠ IDLE).
- overflow  out  1  sticky flag: a write was dropped.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset values (after any edge with rst=1): tx=1, busy=0, full=0, empty=1, count=0, overflow=0, state=IDLE, FIFO pointers=0, bit counter=0, divider=0.
- Reset has priority over every other event. Reset mid-frame aborts the frame: tx=1 after that edge and the FIFO contents are discarded.
- All outputs are registered or derived only from registered state. No combinational path from wr_en to any output.
- Write accept:
  - On an edge with wr_en=1 and full=0 (value before the edge), wr_data is pushed and count increments.
  - If full=1, the byte is dropped and overflow←1. Overflow stays set until rst.
  - Acceptance uses the pre-edge `full` only. A pop on the same edge does not make room for that write.
- Pop and shift: FSM states IDLE, START, DATA, STOP.
  - IDLE: on an edge with empty=0, pop the head into the shift register, tx←0, state←START, divider←0.
    - Write accepted at edge N into an empty FIFO → tx falls at edge N+1.
    - Push and pop on the same edge leave count unchanged.
  - START: hold tx=0 for CLK_DIV cycles, then tx←bit0, state←DATA, bit counter←0.
  - DATA: each bit held CLK_DIV cycles, LSB first. After bit7's CLK_DIV cycles: tx←1, state←STOP.
  - STOP: hold tx=1 for CLK_DIV cycles. At the end:
    - if empty=0, pop immediately and go to START (tx←0). There is no idle gap between frames.
    - otherwise state←IDLE.
- Frame length is exactly 10×CLK_DIV cycles from the tx falling edge to the next possible start-bit edge.
- Divider counts 0..CLK_DIV-1 and wraps. FIFO read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- The `busy` output is 1 in START, DATA and STOP.

Test Plan:
- Single byte, CLK_DIV=4: reset 2 cycles, write 0x55 at edge N.
  - tx=0 over edges N+1..N+4.
  - Data bits 1,0,1,0,1,0,1,0, each 4 cycles.
  - Stop bit high from N+37.
  - busy=0 and empty=1 after N+41.
- Back-to-back: write 0xA5 then 0x3C on consecutive edges.
  - Decoded serial stream is 0xA5 then 0x3C.
  - The second start bit begins exactly 40 cycles after the first.
  - busy stays 1 continuously for 80 cycles.
- Fill and overflow: write 0x01..0x06 on 6 consecutive edges while idle.
  - First byte popped at the second edge.
  - count=4 and full=1 after the 5th write.
  - 6th write dropped, overflow=1.
  - Line output is 0x01..0x05 only. overflow stays 1 until rst.
- Write while full coincident with end-of-frame pop: the write is rejected, count goes 4→3, overflow=1.
- Reset mid-frame: assert rst for 1 cycle during DATA bit3 with 2 bytes queued.
  - Next edge: tx=1, busy=0, count=0, overflow=0.
  - No further frame starts without a new write.
- Divider stress, CLK_DIV=2 and CLK_DIV=7: transmit 0xFF and 0x00.
  - Measured bit period is exactly CLK_DIV cycles.
  - Frame is 10×CLK_DIV cycles.
